s1_unidade_controle: RTL and testbench

//  Moore FSM that sequences the S1 datapath (S1_fluxo_dados) for one game.
//  Per round it plays the stored notes 0..limite, then collects the player's notes, counts errors and updates the score.

---
 rtl/s1_unidade_controle.sv | 197 +++++++++++++++++++
 tb/tb_s1_unidade_controle.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s1_unidade_controle.sv
// -----------------------------------------------------------------------------
// s1_unidade_controle
//   Moore control unit that sequences the S1 datapath through one game.
//   Each round first plays the stored notes 0..limite, then collects the
//   player's notes one by one. It counts wrong presses, scores finished rounds,
//   and ends the game on a win, a player timeout or too many errors.
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   iniciar                  start pulse (honoured in inicial and final states)
//   musica, dificuldade      song / level selects, captured in preparacao
//   enderecoIgualLimite      datapath: endereco == limite
//   botoesIgualMemoria       datapath: registered press matches ROM note
//   fimL                     datapath: current round is the last one
//   jogadafeita              datapath: one-cycle button press pulse
//   timeout, muda_nota       datapath: player timer / note timer expired
//   zeraX / contaX / ...     datapath controls, decoded from the state only
//   memoria, nivel           registered song / level selects
//   pronto, ganhou, perdeu   game finished / result
//   db_estado                current state code (debug)
// -----------------------------------------------------------------------------
module s1_unidade_controle #(
    parameter int unsigned MAX_ERROS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       musica,
    input  logic       dificuldade,
    input  logic       enderecoIgualLimite,
    input  logic       botoesIgualMemoria,
    input  logic       fimL,
    input  logic       jogadafeita,
    input  logic       timeout,
    input  logic       muda_nota,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraT2,
    output logic       contaT2,
    output logic       mostraJ,
    output logic       mostraB,
    output logic       contaErro,
    output logic       zeraErro,
    output logic       zeraPontos,
    output logic       regPontos,
    output logic       sel_memoria_arduino,
    output logic       activateArduino,
    output logic       memoria,
    output logic       nivel,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        MOSTRA_NOTA    = 4'h3,
        PROXIMA_NOTA   = 4'h4,
        PREPARA_JOGADA = 4'h5,
        ESPERA_JOGADA  = 4'h6,
        REGISTRA       = 4'h7,
        COMPARA        = 4'h8,
        PROXIMA_JOGADA = 4'h9,
        FIM_RODADA     = 4'hA,
        ERRO           = 4'hB,
        FIM_TIMEOUT    = 4'hC,
        FIM_GANHOU     = 4'hD,
        FIM_ERROS      = 4'hE,
        PROXIMA_RODADA = 4'hF
    } estado_t;

    localparam logic [3:0] MAX_ERROS_L = 4'(MAX_ERROS);

    estado_t    estado_q, estado_d;
    logic [3:0] erros_q, erros_d;
    logic       memoria_q, memoria_d;
    logic       nivel_q, nivel_d;
    logic [3:0] erros_mais1;

    // Wraps in 4 bits like the datapath counter; erros_q never reaches 15
    // before the game ends because MAX_ERROS <= 15.
    assign erros_mais1 = erros_q + 4'd1;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= INICIAL;
            erros_q   <= 4'd0;
            memoria_q <= 1'b0;
            nivel_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            erros_q   <= erros_d;
            memoria_q <= memoria_d;
            nivel_q   <= nivel_d;
        end
    end

    // Next-state logic.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        estado_d  = estado_q;
        erros_d   = erros_q;
        memoria_d = memoria_q;
        nivel_d   = nivel_q;
        case (estado_q)
            INICIAL:        if (iniciar) estado_d = PREPARACAO;
            PREPARACAO: begin
                memoria_d = musica;
                nivel_d   = dificuldade;
                erros_d   = 4'd0;
                estado_d  = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                erros_d  = 4'd0;
                estado_d = MOSTRA_NOTA;
            end
            MOSTRA_NOTA:
                if (muda_nota)
                    estado_d = enderecoIgualLimite ? PREPARA_JOGADA : PROXIMA_NOTA;
            // Extra cycle lets the synchronous ROM present the next note.
            PROXIMA_NOTA:   estado_d = MOSTRA_NOTA;
            PREPARA_JOGADA: estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA:
                // A press in the same cycle as the timeout still counts.
                if (jogadafeita)  estado_d = REGISTRA;
                else if (timeout) estado_d = FIM_TIMEOUT;
            REGISTRA:       estado_d = COMPARA;
            COMPARA:
                if (!botoesIgualMemoria)      estado_d = ERRO;
                else if (enderecoIgualLimite) estado_d = FIM_RODADA;
                else                          estado_d = PROXIMA_JOGADA;
            PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
            ERRO: begin
                if (erros_q != 4'd15) erros_d = erros_mais1;
                // Address is not advanced: the player retries the same note.
                estado_d = (erros_mais1 == MAX_ERROS_L) ? FIM_ERROS : ESPERA_JOGADA;
            end
            FIM_RODADA:     estado_d = fimL ? FIM_GANHOU : PROXIMA_RODADA;
            PROXIMA_RODADA: estado_d = INICIA_RODADA;
            FIM_TIMEOUT, FIM_GANHOU, FIM_ERROS:
                if (iniciar) estado_d = PREPARACAO;
            default:        estado_d = INICIAL;
        endcase
    end

    // Moore output decode: depends on the state register only.
    always_comb begin
        {zeraR, registraR, zeraL, contaL, zeraE, contaE, zeraT, contaT,
         zeraT2, contaT2, mostraJ, mostraB, contaErro, zeraErro, zeraPontos,
         regPontos, sel_memoria_arduino, activateArduino,
         pronto, ganhou, perdeu} = '0;
        case (estado_q)
            PREPARACAO: begin
                zeraL = 1'b1; zeraE = 1'b1; zeraR = 1'b1; zeraT = 1'b1;
                zeraT2 = 1'b1; zeraErro = 1'b1; zeraPontos = 1'b1;
            end
            INICIA_RODADA: begin
                zeraE = 1'b1; zeraR = 1'b1; zeraT2 = 1'b1; zeraErro = 1'b1;
            end
            MOSTRA_NOTA: begin
                mostraJ = 1'b1; contaT2 = 1'b1;
                sel_memoria_arduino = 1'b1; activateArduino = 1'b1;
            end
            PROXIMA_NOTA:   begin contaE = 1'b1; zeraT2 = 1'b1; end
            PREPARA_JOGADA: begin zeraE = 1'b1; zeraR = 1'b1; zeraT = 1'b1; end
            ESPERA_JOGADA: begin
                mostraB = 1'b1; activateArduino = 1'b1; contaT = 1'b1;
            end
            REGISTRA:       begin registraR = 1'b1; mostraB = 1'b1; end
            PROXIMA_JOGADA: begin contaE = 1'b1; zeraT = 1'b1; end
            ERRO:           begin contaErro = 1'b1; zeraT = 1'b1; end
            FIM_RODADA:     regPontos = 1'b1;
            PROXIMA_RODADA: contaL = 1'b1;
            FIM_TIMEOUT:    begin pronto = 1'b1; perdeu = 1'b1; end
            FIM_GANHOU:     begin pronto = 1'b1; ganhou = 1'b1; end
            FIM_ERROS:      begin pronto = 1'b1; perdeu = 1'b1; end
            default: ;
        endcase
    end

    assign memoria   = memoria_q;
    assign nivel     = nivel_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_s1_unidade_controle.sv
// -----------------------------------------------------------------------------
// tb_s1_unidade_controle
//   Bench for s1_unidade_controle. A reference model derived from the state
//   table (outputs listed by name per state code) is compared on every cycle.
//   Directed games use a small datapath model (counters and timers) and a
//   scripted player; a final phase drives fully random inputs.
// -----------------------------------------------------------------------------
module tb_s1_unidade_controle;

    localparam int MAX_ERROS = 4;

    logic clock;
    logic reset, iniciar, musica, dificuldade, enderecoIgualLimite;
    logic botoesIgualMemoria, fimL, jogadafeita, timeout, muda_nota;
    logic zeraR, registraR, zeraL, contaL, zeraE, contaE, zeraT, contaT;
    logic zeraT2, contaT2, mostraJ, mostraB, contaErro, zeraErro, zeraPontos;
    logic regPontos, sel_memoria_arduino, activateArduino;
    logic memoria, nivel, pronto, ganhou, perdeu;
    logic [3:0] db_estado;

    s1_unidade_controle #(.MAX_ERROS(MAX_ERROS)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .musica(musica),
        .dificuldade(dificuldade), .enderecoIgualLimite(enderecoIgualLimite),
        .botoesIgualMemoria(botoesIgualMemoria), .fimL(fimL),
        .jogadafeita(jogadafeita), .timeout(timeout), .muda_nota(muda_nota),
        .zeraR(zeraR), .registraR(registraR), .zeraL(zeraL), .contaL(contaL),
        .zeraE(zeraE), .contaE(contaE), .zeraT(zeraT), .contaT(contaT),
        .zeraT2(zeraT2), .contaT2(contaT2), .mostraJ(mostraJ), .mostraB(mostraB),
        .contaErro(contaErro), .zeraErro(zeraErro), .zeraPontos(zeraPontos),
        .regPontos(regPontos), .sel_memoria_arduino(sel_memoria_arduino),
        .activateArduino(activateArduino), .memoria(memoria), .nivel(nivel),
        .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bit i of the observed vector is the signal named sig_names[i].
    logic [20:0] act_vec;
    assign act_vec = {perdeu, ganhou, pronto, activateArduino, sel_memoria_arduino,
                      regPontos, zeraPontos, zeraErro, contaErro, mostraB, mostraJ,
                      contaT2, zeraT2, contaT, zeraT, contaE, zeraE, contaL, zeraL,
                      registraR, zeraR};
    string       sig_names [21];
    string       state_outs [16];
    logic [20:0] exp_tab [16];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state.
    int m_state = 0;
    int m_erros = 0;
    bit m_mem   = 1'b0;
    bit m_niv   = 1'b0;

    // Environment: datapath model and scripted player.
    bit         rand_mode   = 1'b0;
    bit         collide_req = 1'b0;
    logic       sel_mus     = 1'b0;
    logic       sel_dif     = 1'b0;
    bit         plan [$];
    int         press_wait  = 2;
    logic [3:0] dp_lim = 4'd0;
    logic [3:0] dp_end = 4'd0;
    int         dp_t  = 0;
    int         dp_t2 = 0;

    // Statistics gathered from DUT outputs during directed games.
    int n_reg, n_cerr, n_wait6, n_runs, bad_runs, t2_run;
    int notes_in_round [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (model state %0d, t=%0t)",
                     name, act, exp, m_state, $time);
        end
    endtask

    function automatic bit has_token(string list, string name);
        int start = 0;
        for (int i = 0; i <= list.len(); i++) begin
            if (i == list.len() || list.getc(i) == 8'd32) begin
                if (i > start && list.substr(start, i - 1) == name) return 1'b1;
                start = i + 1;
            end
        end
        return 1'b0;
    endfunction

    // One clock edge of the game rules, applied to the inputs of this cycle.
    function automatic void model_step();
        int ns;
        if (reset) begin
            m_state = 0; m_erros = 0; m_mem = 1'b0; m_niv = 1'b0;
            return;
        end
        ns = m_state;
        case (m_state)
            0:  ns = iniciar ? 1 : 0;
            1:  begin m_mem = musica; m_niv = dificuldade; m_erros = 0; ns = 2; end
            2:  begin m_erros = 0; ns = 3; end
            3:  if (muda_nota) ns = enderecoIgualLimite ? 5 : 4;
            4:  ns = 3;
            5:  ns = 6;
            6:  if (jogadafeita) ns = 7; else if (timeout) ns = 12;
            7:  ns = 8;
            8:  ns = !botoesIgualMemoria ? 11 : (enderecoIgualLimite ? 10 : 9);
            9:  ns = 6;
            10: ns = fimL ? 13 : 15;
            11: begin
                ns = (((m_erros + 1) % 16) == MAX_ERROS) ? 14 : 6;
                m_erros = (m_erros < 15) ? m_erros + 1 : 15;
            end
            12, 13, 14: if (iniciar) ns = 1;
            15: ns = 2;
            default: ns = 0;
        endcase
        m_state = ns;
    endfunction

    // Inputs for the current cycle, then the datapath reaction at the next edge.
    task automatic drive_cycle();
        if (rand_mode) begin
            reset               = ($urandom_range(0, 399) == 0);
            iniciar             = ($urandom_range(0, 3) == 0);
            musica              = 1'($urandom);
            dificuldade         = 1'($urandom);
            enderecoIgualLimite = 1'($urandom);
            botoesIgualMemoria  = ($urandom_range(0, 3) != 0);
            fimL                = ($urandom_range(0, 3) == 0);
            jogadafeita         = ($urandom_range(0, 2) == 0);
            timeout             = ($urandom_range(0, 15) == 0);
            muda_nota           = ($urandom_range(0, 3) == 0);
        end else begin
            reset               = 1'b0;
            iniciar             = 1'b0;
            musica              = sel_mus;
            dificuldade         = sel_dif;
            enderecoIgualLimite = (dp_end == dp_lim);
            fimL                = (dp_lim == {nivel, 3'b111});
            muda_nota           = (dp_t2 == 499);
            timeout             = (dp_t == 4999);
            jogadafeita         = 1'b0;
            if (db_estado == 4'd6) begin
                if (collide_req) begin
                    jogadafeita = 1'b1; timeout = 1'b1; botoesIgualMemoria = 1'b1;
                    collide_req = 1'b0;
                end else if (plan.size() > 0) begin
                    if (press_wait == 0) begin
                        jogadafeita        = 1'b1;
                        botoesIgualMemoria = plan.pop_front();
                        press_wait         = $urandom_range(1, 15);
                    end else begin
                        press_wait--;
                    end
                end
            end
            if (regPontos) n_reg++;
            if (contaErro) n_cerr++;
            if (db_estado == 4'd6) n_wait6++;
            if (contaT2) t2_run++;
            else if (t2_run > 0) begin
                n_runs++;
                if (t2_run != 500) bad_runs++;
                notes_in_round[dp_lim]++;
                t2_run = 0;
            end
            if (zeraL) dp_lim = 4'd0; else if (contaL) dp_lim = dp_lim + 4'd1;
            if (zeraE) dp_end = 4'd0; else if (contaE) dp_end = dp_end + 4'd1;
            if (zeraT) dp_t = 0;      else if (contaT) dp_t = dp_t + 1;
            if (zeraT2) dp_t2 = 0;    else if (contaT2) dp_t2 = dp_t2 + 1;
        end
    endtask

    // Advance one edge; afterwards the DUT shows the new state and the
    // inputs for that cycle are already applied.
    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        #1;
        drive_cycle();
    endtask

    task automatic run_until(input logic [3:0] target, input int budget, input string name);
        int n = 0;
        while (db_estado !== target && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(db_estado), 32'(target));
    endtask

    task automatic clear_stats();
        n_reg = 0; n_cerr = 0; n_wait6 = 0; n_runs = 0; bad_runs = 0; t2_run = 0;
        for (int i = 0; i < 16; i++) notes_in_round[i] = 0;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("ctl_outputs", 32'(act_vec), 32'(exp_tab[m_state]));
            check("db_estado", 32'(db_estado), 32'(m_state));
            check("memoria", 32'(memoria), 32'(m_mem));
            check("nivel", 32'(nivel), 32'(m_niv));
        end
    end

    initial begin
        sig_names = '{"zeraR", "registraR", "zeraL", "contaL", "zeraE", "contaE",
                      "zeraT", "contaT", "zeraT2", "contaT2", "mostraJ", "mostraB",
                      "contaErro", "zeraErro", "zeraPontos", "regPontos",
                      "sel_memoria_arduino", "activateArduino", "pronto", "ganhou",
                      "perdeu"};
        state_outs[0]  = "";
        state_outs[1]  = "zeraL zeraE zeraR zeraT zeraT2 zeraErro zeraPontos";
        state_outs[2]  = "zeraE zeraR zeraT2 zeraErro";
        state_outs[3]  = "mostraJ contaT2 sel_memoria_arduino activateArduino";
        state_outs[4]  = "contaE zeraT2";
        state_outs[5]  = "zeraE zeraR zeraT";
        state_outs[6]  = "mostraB activateArduino contaT";
        state_outs[7]  = "registraR mostraB";
        state_outs[8]  = "";
        state_outs[9]  = "contaE zeraT";
        state_outs[10] = "regPontos";
        state_outs[11] = "contaErro zeraT";
        state_outs[12] = "pronto perdeu";
        state_outs[13] = "pronto ganhou";
        state_outs[14] = "pronto perdeu";
        state_outs[15] = "contaL";
        for (int s = 0; s < 16; s++)
            for (int b = 0; b < 21; b++)
                exp_tab[s][b] = has_token(state_outs[s], sig_names[b]);

        reset = 1'b1; iniciar = 1'b0; musica = 1'b0; dificuldade = 1'b0;
        enderecoIgualLimite = 1'b0; botoesIgualMemoria = 1'b0; fimL = 1'b0;
        jogadafeita = 1'b0; timeout = 1'b0; muda_nota = 1'b0;
        clear_stats();
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check("reset_db_estado", 32'(db_estado), 32'd0);
        check("reset_outputs", 32'(act_vec), 32'd0);
        check("reset_memoria_nivel", 32'({memoria, nivel}), 32'd0);
        chk_en = 1'b1;
        drive_cycle();

        // Reset while waiting for the player.
        iniciar = 1'b1;
        step();
        run_until(4'd6, 2000, "midgame_reach_espera");
        reset = 1'b1;
        step();
        check("midgame_reset_db", 32'(db_estado), 32'd0);
        check("midgame_reset_outputs", 32'(act_vec), 32'd0);

        // Full game at nivel 0, every press correct.
        clear_stats();
        sel_mus = 1'b1; sel_dif = 1'b0; press_wait = 2;
        repeat (36) plan.push_back(1'b1);
        iniciar = 1'b1;
        step();
        check("start_db_preparacao", 32'(db_estado), 32'd1);
        step();
        check("start_db_inicia_rodada", 32'(db_estado), 32'd2);
        step();
        check("first_note_two_cycles", 32'({db_estado, mostraJ}), 32'({4'd3, 1'b1}));
        run_until(4'd13, 25000, "win_reach_fim_ganhou");
        check("win_regPontos_pulses", 32'(n_reg), 32'd8);
        check("win_result", 32'({pronto, ganhou, perdeu}), 32'b110);
        check("win_memoria", 32'(memoria), 32'd1);
        check("win_note_count", 32'(n_runs), 32'd36);
        check("win_notes_not_500", 32'(bad_runs), 32'd0);
        for (int k = 0; k < 8; k++)
            check($sformatf("win_round%0d_notes", k + 1), 32'(notes_in_round[k]), 32'(k + 1));

        // Restart from fim_ganhou, then let the player time out in round 1.
        clear_stats();
        sel_mus = 1'b0;
        iniciar = 1'b1;
        step();
        check("restart_db_preparacao", 32'(db_estado), 32'd1);
        check("restart_zeraPontos", 32'(zeraPontos), 32'd1);
        step();
        check("restart_db_inicia_rodada", 32'(db_estado), 32'd2);
        step();
        check("restart_db_mostra_nota", 32'(db_estado), 32'd3);
        run_until(4'd12, 7000, "timeout_reach_fim_timeout");
        check("timeout_result", 32'({pronto, ganhou, perdeu}), 32'b101);
        check("timeout_no_regPontos", 32'(n_reg), 32'd0);
        check("timeout_wait_cycles", 32'(n_wait6), 32'd5000);
        check("timeout_memoria_reloaded", 32'(memoria), 32'd0);

        // nivel 1: round 1 has 3 errors then a hit; round 2 has 4 errors.
        clear_stats();
        sel_dif = 1'b1; press_wait = 2;
        plan = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        iniciar = 1'b1;
        step();
        run_until(4'd14, 8000, "errors_reach_fim_erros");
        check("errors_contaErro_pulses", 32'(n_cerr), 32'd7);
        check("errors_round1_scored", 32'(n_reg), 32'd1);
        check("errors_result", 32'({pronto, ganhou, perdeu}), 32'b101);
        check("errors_nivel", 32'(nivel), 32'd1);

        // Press coinciding with timeout in espera_jogada.
        sel_dif = 1'b0; collide_req = 1'b1;
        iniciar = 1'b1;
        step();
        run_until(4'd6, 2000, "collide_reach_espera");
        step();
        check("collide_next_registra", 32'({db_estado, registraR}), 32'({4'd7, 1'b1}));

        // Unconstrained random inputs, including occasional resets.
        rand_mode = 1'b1;
        repeat (15000) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
